// File: rtl/tx_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tx_arbiter_pkg                                          |
// | Brief    : Shared encodings for the TX arbiter: command width,     |
// |            FSM state type and reply-owner tags.                    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Owner tags stored in the reply FIFO and in the owner register
  localparam logic OWNER_PF = 1'b0;
  localparam logic OWNER_SC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tx_arbiter_reply_owner_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : reply_owner_fifo                                        |
// | Brief    : 1-bit-wide owner-tag FIFO, MAX_OUTSTANDING deep. Entry  |
// |            0 is always the head; a pop shifts the array down and   |
// |            a concurrent push lands behind the remaining entries.   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module reply_owner_fifo #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     push,
  input  logic                                     din,
  input  logic                                     pop,
  output logic                                     head,
  output logic                                     full,
  output logic                                     empty,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     count
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] c_max = CW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] r_mem;
  logic [CW-1:0]              r_count;
  logic [MAX_OUTSTANDING-1:0] w_base;
  logic [MAX_OUTSTANDING-1:0] w_hit;
  logic [MAX_OUTSTANDING-1:0] w_mem_nxt;
  logic [CW-1:0]              w_wr_idx;
  logic                       w_push_ok;
  logic                       w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_max);
  assign count     = r_count;
  assign head      = r_mem[0];

  // A push into a full FIFO is only accepted when a pop frees a slot
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // After a pop the surviving entries move down one slot
  assign w_base    = w_pop_ok ? (r_mem >> 1) : r_mem;
  assign w_wr_idx  = w_pop_ok ? (r_count - CW'(1)) : r_count;

  for (genvar i = 0; i < MAX_OUTSTANDING; i++) begin : g_hit
    localparam logic [CW-1:0] c_idx = CW'(i);
    assign w_hit[i] = w_push_ok && (w_wr_idx == c_idx);
  end

  assign w_mem_nxt = (w_base & ~w_hit) | ({MAX_OUTSTANDING{din}} & w_hit);

  // Tag storage and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_count <= '0;
    end else begin
      r_mem <= w_mem_nxt;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tx_arbiter                                              |
// | Brief    : Shares the serial TX command channel between prefetch   |
// |            and scheduler, muxes payload from the granted side and  |
// |            routes RX replies back to their owner in issue order.   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int CMD_BITS        = `TX_CMD_BITS,
  parameter int NSHIFT          = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pf_req_valid,
  input  logic [CMD_BITS-1:0] pf_cmd,
  input  logic                pf_reply_wanted,
  input  logic [NSHIFT-1:0]   pf_data,
  output logic                pf_started,
  output logic                pf_data_next,
  output logic                pf_done,
  input  logic                sc_req_valid,
  input  logic [CMD_BITS-1:0] sc_cmd,
  input  logic                sc_reply_wanted,
  input  logic [NSHIFT-1:0]   sc_data,
  input  logic                sc_reserve,
  output logic                sc_started,
  output logic                sc_data_next,
  output logic                sc_done,
  output logic                tx_command_valid,
  output logic [CMD_BITS-1:0] tx_command,
  output logic                tx_reply_wanted,
  input  logic                tx_command_started,
  input  logic                tx_data_next,
  input  logic                tx_done,
  output logic [NSHIFT-1:0]   tx_data,
  input  logic                rx_active,
  input  logic                rx_done,
  output logic                rx_pf_active,
  output logic                rx_sc_active,
  output logic                rx_unexpected
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  state_t        r_state;
  logic          r_owner;
  logic          r_rx_unexpected;

  logic          w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_count;
  logic          w_pf_elig;
  logic          w_sc_elig;
  logic          w_in_grant;
  logic          w_in_busy;
  logic          w_started;
  logic          w_done;
  logic          w_dnext;
  logic          w_push;
  logic          w_pop;
  logic          w_rx_route;

  // Reply-wanting requests wait while every reply slot is taken;
  // sc_reserve holds off new prefetch grants only
  assign w_sc_elig = sc_req_valid && (!sc_reply_wanted || !w_fifo_full);
  assign w_pf_elig = pf_req_valid && (!pf_reply_wanted || !w_fifo_full) && !sc_reserve;

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_in_busy  = (r_state == ST_BUSY);

  // Command fields are taken live from the owner while in GRANT
  assign tx_command_valid = w_in_grant;
  assign tx_command       = w_in_grant ? ((r_owner == OWNER_SC) ? sc_cmd : pf_cmd) : '0;
  assign tx_reply_wanted  = w_in_grant &&
                            ((r_owner == OWNER_SC) ? sc_reply_wanted : pf_reply_wanted);
  assign tx_data          = w_in_busy ? ((r_owner == OWNER_SC) ? sc_data : pf_data) : '0;

  // Link strobes: done may coincide with started for payload-less commands
  assign w_started = w_in_grant && tx_command_started;
  assign w_done    = tx_done && (w_in_busy || w_started);
  assign w_dnext   = w_in_busy && tx_data_next;

  assign pf_started   = w_started && (r_owner == OWNER_PF);
  assign pf_data_next = w_dnext   && (r_owner == OWNER_PF);
  assign pf_done      = w_done    && (r_owner == OWNER_PF);
  assign sc_started   = w_started && (r_owner == OWNER_SC);
  assign sc_data_next = w_dnext   && (r_owner == OWNER_SC);
  assign sc_done      = w_done    && (r_owner == OWNER_SC);

  // Reply bookkeeping
  assign w_push       = w_started && tx_reply_wanted;
  assign w_pop        = rx_done && !w_fifo_empty;
  assign w_rx_route   = rx_active && !w_fifo_empty;
  assign rx_pf_active = w_rx_route && (w_fifo_head == OWNER_PF);
  assign rx_sc_active = w_rx_route && (w_fifo_head == OWNER_SC);
  assign rx_unexpected = r_rx_unexpected;

  reply_owner_fifo #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_reply_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (r_owner),
    .pop   (w_pop),
    .head  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_count)
  );

  // Arbitration FSM: scheduler has priority, owner latched at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWNER_PF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sc_elig) begin
            r_owner <= OWNER_SC;
            r_state <= ST_GRANT;
          end else if (w_pf_elig) begin
            r_owner <= OWNER_PF;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (tx_command_started) begin
            r_state <= tx_done ? ST_IDLE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tx_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag: any reply activity while no owner is recorded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_unexpected <= 1'b0;
    end else if ((rx_done || rx_active) && (w_count == '0)) begin
      r_rx_unexpected <= 1'b1;
    end
  end

endmodule
`default_nettype wire
